mmio_host_port: RTL
===================

# mmio_host_port

Synthesizable host-interface block on the data-memory write path of the core. It decodes stores to the console and exit MMIO addresses and keeps them from reaching RAM. Console characters from up to four channels are buffered in a tagged FIFO and drained over a valid/ready stream. Exit requests, and optionally PC-stall timeouts, are reported only after the buffer has fully drained.

## Interface
- `NCHAN`, 1: number of console channels, 1..4; channel n lives at `ADDR_PUTC + 4*n`.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `ADDR_PUTC`, 32'h8000_001c: channel-0 console address.
- `ADDR_EXIT`, 32'h8000_002c: exit address.
- `TIMEOUT`, 100: PC-unchanged cycles before timeout; ≥1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_wready`  in  1  core store strobe, one cycle per store.
- `s_waddr`  in  32  store address.
- `s_wdata`  in  32  store data.
- `s_wstrb`  in  4  store byte enables; forwarded unchanged.
- `m_wready`  out  1  store strobe to RAM; combinational `s_wready & ~hit`.
- `pc`  in  32  core fetch PC, sampled every cycle.
- `tx_valid`  out  1  FIFO head valid.
- `tx_ready`  in  1  sink accepts head.
- `tx_data`  out  8  character at FIFO head.
- `tx_chan`  out  2  channel tag of head.
- `overflow`  out  1  sticky; a character was dropped.
- `drop_cnt`  out  16  saturating count of dropped characters.
- `exit_valid`  out  1  sticky; run finished and FIFO drained.
- `exit_code`  out  32  exit value, valid while `exit_valid`.
- `timeout`  out  1  sticky; finish caused by watchdog.

## Operation
- `hit` = `s_wready` and `s_waddr` equals `ADDR_EXIT` or any `ADDR_PUTC + 4*n`, n<NCHAN; `wstrb` is ignored for decode.
- Putc hit in RUN: push {n, `s_wdata[7:0]`}.
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the character is dropped: `overflow`←1, `drop_cnt`+1, saturating at 16'hFFFF.
- Pop: `tx_valid & tx_ready`. The FIFO is show-ahead; `tx_data`/`tx_chan` come from the head register.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the rest are equal.
- FSM states RUN, DRAIN, DONE.
  - RUN→DRAIN on an exit hit: latch `s_wdata` into `exit_code`.
  - RUN→DRAIN on watchdog expiry: `exit_code`←32'hFFFF_FFFF, `timeout`←1.
  - Exit hit and watchdog expiry in the same cycle: the exit hit wins and `timeout` stays 0.
  - DRAIN→DONE when the FIFO is empty; `exit_valid`←1.
  - DONE is terminal until reset.
- In DRAIN/DONE: putc and exit hits are still masked from RAM and are silently discarded. They do not count as drops.
- Reset mid-operation clears the FIFO, counters, sticky flags and FSM immediately. Buffered characters are lost.

## Timing
- Reset values: all outputs 0; state RUN; `prev_pc`=0, watchdog count 0.
- `m_wready` is combinational, with zero latency.
- Putc hit at edge k makes `tx_valid`=1 after edge k, provided the FIFO was empty.
- Exit hit at edge k with the FIFO empty:
  - state DRAIN after edge k;
  - `exit_valid`=1 after edge k+1.
- With M entries queued, `exit_valid` rises one cycle after the pop of the last entry.
- Watchdog:
  - each cycle `prev_pc`←`pc`;
  - `cnt` increments (saturating) when `pc==prev_pc`, and clears otherwise;
  - expiry is `cnt==TIMEOUT` in RUN;
  - width is $clog2(TIMEOUT+1).

## Configuration
- `HOST_WATCHDOG_EN` defined: the watchdog counter and `prev_pc` are built, and timeout finish is active.
- Not defined: no counter and no `prev_pc` register. `timeout` is tied 0 and `pc` is unused. Only an exit write leaves RUN.

## Test plan
- NCHAN=2. Putc 0x41 to channel 0, then 0x42 to `ADDR_PUTC+4`, with `tx_ready`=1 → stream (0,0x41),(1,0x42); `m_wready`=0 on both stores.
- DEPTH=4, `tx_ready`=0. Six putc writes → first 4 queued, `overflow`=1, `drop_cnt`=2; a normal store to 0x0000_1000 passes with `m_wready`=1.
- FIFO full, then putc with simultaneous pop → accepted; `drop_cnt` unchanged.
- Three characters queued with `tx_ready`=0, then exit write 0x0000_0007 → `exit_valid` stays 0. Enable `tx_ready` → `exit_valid`=1 and `exit_code`=7 one cycle after the third pop. A later putc is masked and not counted.
- `HOST_WATCHDOG_EN`, TIMEOUT=100, `pc` held at 0x200 → `timeout`=1, `exit_code`=32'hFFFF_FFFF after drain.
  - An exit write landing on the expiry cycle gives `timeout`=0 and the written code.
  - Without the macro, the same stimulus never finishes.
- `reset` pulsed during DRAIN with 2 characters queued → `tx_valid`=0, `exit_valid`=0, `overflow`=0 immediately; state RUN.

Source files
------------

// File: rtl/mmio_host_port.sv
// Host MMIO port: diverts console/exit stores away from RAM, buffers console bytes in a tagged FIFO.
// Optional PC-stall watchdog finish is built when HOST_WATCHDOG_EN is defined.
module mmio_host_port #(
   parameter int          NCHAN     = 1,
   parameter int          DEPTH     = 16,
   parameter logic [31:0] ADDR_PUTC = 32'h8000_001c,
   parameter logic [31:0] ADDR_EXIT = 32'h8000_002c,
   parameter int          TIMEOUT   = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_wready,
   input  logic [31:0] s_waddr,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   output logic        m_wready,
   output logic [3:0]  m_wstrb,
   input  logic [31:0] pc,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic [1:0]  tx_chan,
   output logic        overflow,
   output logic [15:0] drop_cnt,
   output logic        exit_valid,
   output logic [31:0] exit_code,
   output logic        timeout,
   output logic [1:0]  dbg_state_o
);

   localparam int AW = $clog2(DEPTH);

   // tx stream: a byte moves when tx_valid and tx_ready are both high at a rising edge;
   // tx_valid never depends on tx_ready and the head holds steady until it is taken.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e      state_q;
   logic        exit_valid_q;
   logic [31:0] exit_code_q;
   logic        timeout_q;

   logic        putc_match;
   logic [1:0]  putc_chan;
   logic        exit_match;
   logic        hit;
   logic        putc_hit;
   logic        exit_hit;

   always_comb begin
      putc_match = 1'b0;
      putc_chan  = 2'd0;
      for (int n = 0; n < NCHAN; n++) begin
         if (s_waddr == ADDR_PUTC + 32'(4 * n)) begin
            putc_match = 1'b1;
            putc_chan  = 2'(n);
         end
      end
   end

   assign exit_match = (s_waddr == ADDR_EXIT);
   assign hit        = s_wready & (putc_match | exit_match);
   assign putc_hit   = s_wready & putc_match;
   assign exit_hit   = s_wready & exit_match;
   assign m_wready   = s_wready & ~hit;
   assign m_wstrb    = s_wstrb;

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [9:0]  mem_q [DEPTH];
   logic [9:0]  head;
   logic        fifo_empty;
   logic        fifo_full;
   logic        pop;
   logic        push_req;
   logic        push;
   logic        drop;
   logic        overflow_q, overflow_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = tx_valid & tx_ready;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign push_req   = putc_hit & (state_q == RUN);
   assign push       = push_req & (~fifo_full | pop);
   assign drop       = push_req & ~push;

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != 16'hFFFF) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 16'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {putc_chan, s_wdata[7:0]};
      end
   end

   assign head     = mem_q[rd_ptr_q[AW-1:0]];
   assign tx_valid = ~fifo_empty;
   assign tx_data  = tx_valid ? head[7:0] : 8'h00;
   assign tx_chan  = tx_valid ? head[9:8] : 2'd0;
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

   logic wd_expire;

`ifdef HOST_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [31:0]   prev_pc_q;
   logic [CW-1:0] wd_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_pc_q <= 32'd0;
         wd_cnt_q  <= '0;
      end else begin
         prev_pc_q <= pc;
         if (pc != prev_pc_q) begin
            wd_cnt_q <= '0;
         end else if (wd_cnt_q != CW'(TIMEOUT)) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
         end
      end
   end

   assign wd_expire = (wd_cnt_q == CW'(TIMEOUT));
`else
   logic unused_pc;
   assign unused_pc = ^pc;
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RUN;
         exit_valid_q <= 1'b0;
         exit_code_q  <= 32'd0;
         timeout_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               // An exit store on the expiry cycle takes priority over the watchdog.
               if (exit_hit) begin
                  state_q     <= DRAIN;
                  exit_code_q <= s_wdata;
               end else if (wd_expire) begin
                  state_q     <= DRAIN;
                  exit_code_q <= 32'hFFFF_FFFF;
                  timeout_q   <= 1'b1;
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state_q      <= DONE;
                  exit_valid_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign exit_valid  = exit_valid_q;
   assign exit_code   = exit_code_q;
   assign timeout     = timeout_q;
   assign dbg_state_o = state_q;

endmodule
